// File: rtl/tanh_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tanh_iter_sequencer
// Purpose  : Control FSM that loads an operand, handshakes with the busy-flag
//            selector, steps N_ITER tanh iterations and presents the result.
// Revision : 1.0
// ============================================================================
module tanh_iter_sequencer #(
    parameter int N_ITER = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    input  logic             sel_state,
    output logic             sel_mux1,
    output logic             sel_mux2,
    output logic             load_en,
    output logic             iter_en,
    output logic [CNT_W-1:0] iter_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ITER    = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(N_ITER - 1);
    localparam logic [CNT_W-1:0] c_IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;
    logic             r_mux1_q;

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_mux1_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_mux1_q <= sel_mux1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = '0;
        in_ready    = 1'b0;
        load_en     = 1'b0;
        sel_mux1    = 1'b0;
        sel_mux2    = 1'b0;
        iter_en     = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                // Gated by reset so no load is requested until reset releases.
                load_en  = in_valid & ~reset_b;
                sel_mux1 = load_en;
                if (load_en) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                sel_mux1 = 1'b1;
                if (abort) begin
                    w_state_nxt = S_RELEASE;
                end else if (sel_state) begin
                    w_state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                iter_en = 1'b1;
                if (abort) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                sel_mux2  = out_ready;
                if (abort || out_ready) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                sel_mux2 = 1'b1;
                // A request raised last cycle may still be landing in the selector.
                if (!sel_state && !r_mux1_q) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign iter_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tanh_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_iter_sequencer
// Purpose  : Self-checking bench for tanh_iter_sequencer with selector models.
// Revision : 1.0
// ============================================================================
module tb_tanh_iter_sequencer;

    logic clock = 1'b0;
    logic reset_b;
    always #5 clock = ~clock;

    logic       a_in_valid, a_in_ready, a_abort, a_sel_state, a_sel_mux1, a_sel_mux2;
    logic       a_load_en, a_iter_en, a_out_valid, a_out_ready, a_sel_block;
    logic [3:0] a_iter_idx;
    logic       b_in_valid, b_in_ready, b_abort, b_sel_state, b_sel_mux1, b_sel_mux2;
    logic       b_load_en, b_iter_en, b_out_valid, b_out_ready;
    logic [3:0] b_iter_idx;

    tanh_iter_sequencer #(.N_ITER(8), .CNT_W(4)) u_dut_a (
        .clock(clock), .reset_b(reset_b), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .abort(a_abort), .sel_state(a_sel_state), .sel_mux1(a_sel_mux1), .sel_mux2(a_sel_mux2),
        .load_en(a_load_en), .iter_en(a_iter_en), .iter_idx(a_iter_idx),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    tanh_iter_sequencer #(.N_ITER(1), .CNT_W(4)) u_dut_b (
        .clock(clock), .reset_b(reset_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .abort(b_abort), .sel_state(b_sel_state), .sel_mux1(b_sel_mux1), .sel_mux2(b_sel_mux2),
        .load_en(b_load_en), .iter_en(b_iter_en), .iter_idx(b_iter_idx),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    // Selector models: request sets busy, release clears it; a_sel_block pins it idle.
    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b)          a_sel_state <= 1'b0;
        else if (a_sel_block) a_sel_state <= 1'b0;
        else if (a_sel_mux1)  a_sel_state <= 1'b1;
        else if (a_sel_mux2)  a_sel_state <= 1'b0;
    end

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b)         b_sel_state <= 1'b0;
        else if (b_sel_mux1) b_sel_state <= 1'b1;
        else if (b_sel_mux2) b_sel_state <= 1'b0;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int a_sb[$];
    int b_sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] a_obs();
        return {a_in_ready, a_load_en, a_sel_mux1, a_iter_en, a_out_valid, a_sel_mux2, a_iter_idx};
    endfunction

    function automatic logic [9:0] b_obs();
        return {b_in_ready, b_load_en, b_sel_mux1, b_iter_en, b_out_valid, b_sel_mux2, b_iter_idx};
    endfunction

    // Scoreboards: each out_valid rise must match the cycle predicted at accept time.
    logic a_ov_prev = 1'b0;
    logic b_ov_prev = 1'b0;
    always @(negedge clock) begin
        if (a_out_valid && !a_ov_prev) begin
            if (a_sb.size() == 0) check("a_unexpected_out_valid", 32'(a_out_valid), 32'd0);
            else                  check("a_out_valid_cycle", 32'(cyc), 32'(a_sb.pop_front()));
        end
        if (b_out_valid && !b_ov_prev) begin
            if (b_sb.size() == 0) check("b_unexpected_out_valid", 32'(b_out_valid), 32'd0);
            else                  check("b_out_valid_cycle", 32'(cyc), 32'(b_sb.pop_front()));
        end
        a_ov_prev = a_out_valid;
        b_ov_prev = b_out_valid;
    end

    task automatic start_a(input bit push, input int extra);
        a_in_valid = 1'b1;
        if (push) a_sb.push_back(cyc + 10 + extra);
        @(negedge clock);
        check("a_accept", 32'(a_load_en), 32'd1);
        tick();
        a_in_valid = 1'b0;
    endtask

    // Returns at the negedge where the condition holds (or after a timeout).
    task automatic wait_a(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if ((which == 0 && a_out_valid) ||
                (which == 1 && a_iter_en && a_iter_idx == 4'd3) ||
                (which == 2 && a_in_ready)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle_a(input string name);
        bit ok;
        wait_a(2, ok);
        check(name, 32'(ok), 32'd1);
        tick();
    endtask

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       ab;
        logic [5:0] flags;   // in_ready, load_en, sel_mux1, iter_en, out_valid, sel_mux2
        logic [3:0] idx;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Accept with abort (ignored), in_valid during ITER (ignored), abort in RELEASE (ignored).
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 6'b111000, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 6'b001000, 4'd0};
        for (int k = 2; k <= 9; k++)
            tbl[k] = '{(k == 3 || k == 4), 1'b1, 1'b0, 6'b000100, 4'(k - 2)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 6'b000011, 4'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 6'b000001, 4'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 6'b100000, 4'd0};

        reset_b = 1'b1;
        a_in_valid = 1'b0; a_abort = 1'b0; a_out_ready = 1'b1; a_sel_block = 1'b0;
        b_in_valid = 1'b0; b_abort = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        @(negedge clock);
        check("a_reset_outputs", 32'(a_obs()), 32'({6'b100000, 4'd0}));
        check("b_reset_outputs", 32'(b_obs()), 32'({6'b100000, 4'd0}));
        @(posedge clock);
        #1;
        reset_b = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        tick();

        // Nominal N_ITER=8 operation, cycle by cycle.
        a_sb.push_back(cyc + 10);
        for (int r = 0; r < 13; r++) begin
            a_in_valid  = tbl[r].iv;
            a_out_ready = tbl[r].ordy;
            a_abort     = tbl[r].ab;
            @(negedge clock);
            check($sformatf("vec_row%0d", r), 32'(a_obs()), 32'({tbl[r].flags, tbl[r].idx}));
            tick();
        end
        a_in_valid = 1'b0;
        a_abort    = 1'b0;

        // Downstream stall in HOLD for 5 cycles.
        a_out_ready = 1'b0;
        start_a(1'b1, 0);
        wait_a(0, ok);
        check("stall_reach_hold", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                @(negedge clock);
            end
            check("stall_hold", 32'({a_out_valid, a_sel_mux2, a_iter_idx}), 32'({2'b10, 4'd0}));
        end
        tick();
        a_out_ready = 1'b1;
        @(negedge clock);
        check("stall_handshake", 32'({a_out_valid, a_sel_mux2}), 32'(2'b11));
        tick();
        @(negedge clock);
        check("stall_single_handshake", 32'({a_out_valid, a_sel_mux2}), 32'(2'b01));
        tick();
        wait_idle_a("stall_back_idle");

        // Abort at iteration index 3.
        start_a(1'b0, 0);
        wait_a(1, ok);
        check("abort_reach_idx3", 32'(ok), 32'd1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        @(negedge clock);
        check("abort_release", 32'({a_out_valid, a_sel_mux2, a_iter_en}), 32'(3'b010));
        tick();
        @(negedge clock);
        check("abort_release_hold", 32'({a_out_valid, a_sel_mux2}), 32'(2'b01));
        tick();
        @(negedge clock);
        check("abort_in_ready", 32'({a_in_ready, a_sel_mux2}), 32'(2'b10));
        repeat (6) tick();

        // Selector slow to go busy: ARM must wait on sel_state.
        a_sel_block = 1'b1;
        start_a(1'b1, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            check("arm_wait", 32'({a_sel_mux1, a_iter_en}), 32'(2'b10));
            if (k == 4) a_sel_block = 1'b0;
            tick();
        end
        @(negedge clock);
        check("arm_sees_busy", 32'({a_sel_mux1, a_iter_en}), 32'(2'b10));
        tick();
        @(negedge clock);
        check("iter_starts", 32'({a_sel_mux1, a_iter_en, a_iter_idx}), 32'({2'b01, 4'd0}));
        tick();
        wait_idle_a("slowsel_back_idle");

        // Asynchronous reset between edges while in HOLD.
        a_out_ready = 1'b0;
        start_a(1'b1, 0);
        wait_a(0, ok);
        check("reset_reach_hold", 32'(ok), 32'd1);
        #2;
        reset_b = 1'b1;
        #1;
        check("async_reset_hold", 32'({a_out_valid, a_in_ready, a_sel_mux2}), 32'(3'b010));
        @(posedge clock);
        #1;
        reset_b = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("after_reset_idle", 32'(a_obs()), 32'({6'b100000, 4'd0}));
            tick();
        end

        // N_ITER=1 with in_valid held high: one accept every 5 cycles.
        b_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) b_sb.push_back(cyc + 5 * k + 3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check($sformatf("b2b_k%0d", k), 32'({b_in_ready, b_load_en}),
                  (k % 5 == 0) ? 32'd3 : 32'd0);
            tick();
        end
        b_in_valid = 1'b0;
        repeat (4) tick();

        check("a_scoreboard_drained", 32'(a_sb.size()), 32'd0);
        check("b_scoreboard_drained", 32'(b_sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
